switch_event_encoder: RTL

SWITCH_EVENT_ENCODER -- requirements
Module: switch_event_encoder

---
 rtl/switch_event_encoder_pkg.sv | 37 +++
 rtl/switch_event_encoder_sync.sv | 25 ++
 rtl/switch_event_encoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/switch_event_encoder_pkg.sv
// Shared definitions for the switch event encoder.
//   state_t      : debounce FSM state encoding
//   CODE_SW0..3  : encoded switch index for each one-hot input
//   is_one_hot   : true when exactly one bit of a 4-bit pattern is set
//   encode_sw    : maps a one-hot pattern to its 2-bit index
package switch_event_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } state_t;

  localparam logic [1:0] CODE_SW0 = 2'b00;
  localparam logic [1:0] CODE_SW1 = 2'b01;
  localparam logic [1:0] CODE_SW2 = 2'b10;
  localparam logic [1:0] CODE_SW3 = 2'b11;

  function automatic logic is_one_hot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] encode_sw(input logic [3:0] p);
    logic [1:0] c;
    c = CODE_SW0;
    case (p)
      4'b0001: c = CODE_SW0;
      4'b0010: c = CODE_SW1;
      4'b0100: c = CODE_SW2;
      4'b1000: c = CODE_SW3;
      default: c = CODE_SW0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/switch_event_encoder_sync.sv
// Two-flop synchronizer for the raw switch inputs.
//   clk   : system clock
//   reset : synchronous, active-high; clears both stages
//   d     : raw asynchronous switch levels
//   q     : synchronized switch levels
module switch_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] stage1;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/switch_event_encoder.sv
// Debounces four one-hot switches and reports each legal press as an
// encoded event; debounced multi-hot patterns raise an error strobe.
//   clk   : system clock
//   reset : synchronous, active-high
//   sw    : raw asynchronous switch inputs
//   valid : one-cycle strobe for a debounced one-hot press
//   code  : index of the pressed switch, updated only with valid
//   error : one-cycle strobe for a debounced multi-hot pattern
//   busy  : high whenever the FSM is outside IDLE
module switch_event_encoder
  import switch_event_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  output logic       valid,
  output logic [1:0] code,
  output logic       error,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The capture sample in IDLE already counts as the first stable press
  // cycle, so PRESS_DB fires one count earlier than RELEASE_DB, which must
  // see DEBOUNCE_CYCLES zero samples after entry or after any glitch.
  localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  logic [3:0]    sw_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    pattern, pattern_n;
  logic          valid_n, error_n, busy_n;
  logic [1:0]    code_n;

  switch_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pattern_n = pattern;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    code_n    = code;
    case (state)
      ST_IDLE: begin
        if (sw_s != 4'd0) begin
          pattern_n = sw_s;
          cnt_n     = '0;
          state_n   = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (sw_s == 4'd0) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (sw_s != pattern) begin
          pattern_n = sw_s;
          cnt_n     = '0;
        end else if (cnt >= PRESS_LAST) begin
          state_n = ST_HELD;
          if (is_one_hot(pattern)) begin
            valid_n = 1'b1;
            code_n  = encode_sw(pattern);
          end else begin
            error_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_HELD: begin
        if (sw_s == 4'd0) begin
          cnt_n   = '0;
          state_n = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        if (sw_s != 4'd0) begin
          cnt_n = '0;
        end else if (cnt >= REL_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pattern <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
      code    <= CODE_SW0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pattern <= pattern_n;
      valid   <= valid_n;
      error   <= error_n;
      code    <= code_n;
      busy    <= busy_n;
    end
  end

endmodule
